mm_stream_engine: RTL and testbench



---
 rtl/mm_pkg.sv | 33 +++
 rtl/mm_stream_engine_mac_unit.sv | 45 ++++
 rtl/mm_stream_engine.sv | 195 +++++++++++++++++++
 tb/tb_mm_stream_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types, default widths and the saturating-add helper for the matrix stream engine.
// The helper is only used when the MM_SAT_EN build option is defined.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    EMIT,
    DONE
  } mm_state_e;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_MAX_DIM        = 4;
  localparam int DEF_OUT_DATA_WIDTH = 20;
  localparam int DEF_IDX_W          = 2;
  localparam int DEF_DIM_W          = 3;

  // Signed add clamped to the range of a 'width'-bit two's-complement value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/mm_stream_engine_mac_unit.sv
// Signed multiply-accumulate with clear/enable; the accumulator saturates when
// MM_SAT_EN is defined and wraps modulo 2^OUT_DATA_WIDTH otherwise.
module mm_mac_unit
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             en,
  input  logic signed [DATA_WIDTH-1:0]     a,
  input  logic signed [DATA_WIDTH-1:0]     b,
  output logic signed [OUT_DATA_WIDTH-1:0] acc
);

  logic signed [2*DATA_WIDTH-1:0]   prod;
  logic signed [OUT_DATA_WIDTH-1:0] prod_ext;
  logic signed [OUT_DATA_WIDTH-1:0] acc_d;
  logic signed [OUT_DATA_WIDTH-1:0] acc_q;

  always_comb begin
    prod     = a * b;
    prod_ext = OUT_DATA_WIDTH'(prod);
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
`ifdef MM_SAT_EN
      acc_d = OUT_DATA_WIDTH'(sat_add(64'(acc_q), 64'(prod_ext), OUT_DATA_WIDTH));
`else
      acc_d = acc_q + prod_ext;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mm_stream_engine.sv
// Sequential C = A*B engine: one MAC per cycle, results streamed row-major over valid/ready.
// Define MM_SAT_EN to make the accumulator saturate instead of wrap.
module mm_stream_engine
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_DIM        = DEF_MAX_DIM,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
  parameter int IDX_W          = DEF_IDX_W,
  parameter int DIM_W          = DEF_DIM_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic                             wr_sel,
  input  logic [IDX_W-1:0]                 wr_row,
  input  logic [IDX_W-1:0]                 wr_col,
  input  logic signed [DATA_WIDTH-1:0]     wr_data,
  input  logic [DIM_W-1:0]                 dim_m,
  input  logic [DIM_W-1:0]                 dim_k,
  input  logic [DIM_W-1:0]                 dim_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             cfg_err,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_W-1:0]                 out_row,
  output logic [IDX_W-1:0]                 out_col,
  output logic signed [OUT_DATA_WIDTH-1:0] out_data,
  output logic                             done
);

  mm_state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] mem_a_q [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] mem_a_d [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] mem_b_q [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] mem_b_d [MAX_DIM][MAX_DIM];

  logic [DIM_W-1:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] k_idx;

  logic [IDX_W-1:0]                 out_row_q, out_row_d, out_col_q, out_col_d;
  logic signed [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                             cfg_err_q, cfg_err_d;

  logic                             mac_clr, mac_en;
  logic signed [DATA_WIDTH-1:0]     mac_a, mac_b;
  logic signed [OUT_DATA_WIDTH-1:0] acc;

  logic dims_ok, wr_in_range, last_elem, mac_active;

  mm_mac_unit #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OUT_DATA_WIDTH(OUT_DATA_WIDTH)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (mac_a),
    .b    (mac_b),
    .acc  (acc)
  );

  assign dims_ok = (dim_m != '0) && (int'(dim_m) <= MAX_DIM) &&
                   (dim_k != '0) && (int'(dim_k) <= MAX_DIM) &&
                   (dim_n != '0) && (int'(dim_n) <= MAX_DIM);
  assign wr_in_range = (int'(wr_row) < MAX_DIM) && (int'(wr_col) < MAX_DIM);
  assign last_elem   = (DIM_W'(i_q) == dim_m_q - DIM_W'(1)) &&
                       (DIM_W'(j_q) == dim_n_q - DIM_W'(1));
  assign mac_active  = (k_q < dim_k_q);
  assign k_idx       = k_q[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    mem_a_d    = mem_a_q;
    mem_b_d    = mem_b_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_n_d    = dim_n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    out_data_d = out_data_q;
    cfg_err_d  = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    if (mac_active) begin
      mac_a = mem_a_q[i_q][k_idx];
      mac_b = mem_b_q[k_idx][j_q];
    end

    case (state_q)
      IDLE: begin
        if (wr_en && wr_in_range) begin
          if (wr_sel) mem_b_d[wr_row][wr_col] = wr_data;
          else        mem_a_d[wr_row][wr_col] = wr_data;
        end
        if (start) begin
          if (dims_ok) begin
            dim_m_d = dim_m;
            dim_k_d = dim_k;
            dim_n_d = dim_n;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = MAC;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      // k runs 0..dim_k: dim_k accumulate cycles, then one cycle to register the result.
      MAC: begin
        if (mac_active) begin
          mac_en = 1'b1;
          k_d    = k_q + DIM_W'(1);
        end else begin
          out_data_d = acc;
          out_row_d  = i_q;
          out_col_d  = j_q;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_elem) begin
            state_d = DONE;
          end else begin
            if (DIM_W'(j_q) == dim_n_q - DIM_W'(1)) begin
              j_d = '0;
              i_d = i_q + IDX_W'(1);
            end else begin
              j_d = j_q + IDX_W'(1);
            end
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = MAC;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_a_q    <= '{default: '0};
      mem_b_q    <= '{default: '0};
      dim_m_q    <= '0;
      dim_k_q    <= '0;
      dim_n_q    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_a_q    <= mem_a_d;
      mem_b_q    <= mem_b_d;
      dim_m_q    <= dim_m_d;
      dim_k_q    <= dim_k_d;
      dim_n_q    <= dim_n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign cfg_err   = cfg_err_q;
  assign out_valid = (state_q == EMIT);
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_data  = out_data_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mm_stream_engine.sv
// Self-checking bench for mm_stream_engine against an arithmetic matrix-product model.
// Built with a 16-bit result width so the overflow case exercises MM_SAT_EN / wrap.
module tb_mm_stream_engine;

  localparam int DW  = 8;
  localparam int MD  = 4;
  localparam int OW  = 16;
  localparam int IW  = 2;
  localparam int DMW = 3;

  logic                 clk = 1'b0;
  logic                 reset, wr_en, wr_sel, start, out_ready;
  logic [IW-1:0]        wr_row, wr_col;
  logic signed [DW-1:0] wr_data;
  logic [DMW-1:0]       dim_m, dim_k, dim_n;
  logic                 busy, cfg_err, out_valid, done;
  logic [IW-1:0]        out_row, out_col;
  logic signed [OW-1:0] out_data;

  int vectors = 0;
  int errors  = 0;
  int ma [MD][MD];
  int mb [MD][MD];

  mm_stream_engine #(
    .DATA_WIDTH    (DW),
    .MAX_DIM       (MD),
    .OUT_DATA_WIDTH(OW),
    .IDX_W         (IW),
    .DIM_W         (DMW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .dim_m    (dim_m),
    .dim_k    (dim_k),
    .dim_n    (dim_n),
    .start    (start),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_data (out_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accumulate step of the reference: exact sum, then saturate or wrap to OW bits.
  function automatic longint acc_step(input longint acc, input longint p);
    longint s;
    logic signed [OW-1:0] t;
    longint hi, lo;
    s  = acc + p;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
`ifdef MM_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    t = OW'(s);
    return longint'(t);
`endif
  endfunction

  function automatic longint expect_c(input int r, input int c, input int k);
    longint acc = 0;
    for (int kk = 0; kk < k; kk++) acc = acc_step(acc, longint'(ma[r][kk] * mb[kk][c]));
    return acc;
  endfunction

  task automatic write_op(input bit sel, input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(r);
    wr_col  = IW'(c);
    wr_data = DW'(v);
    tick();
    wr_en = 1'b0;
    if (sel) mb[r][c] = v;
    else     ma[r][c] = v;
  endtask

  task automatic load_random();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        write_op(1'b0, r, c, int'($urandom_range(255)) - 128);
        write_op(1'b1, r, c, int'($urandom_range(255)) - 128);
      end
  endtask

  // Starts a multiply and consumes every element; bp stalls each element 7 cycles
  // while attempting (ignored) operand writes.
  task automatic run(input int m, input int k, input int n, input bit bp);
    int waited;
    bit timed_out;
    dim_m     = DMW'(m);
    dim_k     = DMW'(k);
    dim_n     = DMW'(n);
    start     = 1'b1;
    out_ready = !bp;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", busy, 1);
    timed_out = 1'b0;
    for (int e = 0; e < m * n && !timed_out; e++) begin
      waited = 0;
      while (!out_valid && waited < 200) begin
        tick();
        waited++;
      end
      if (!out_valid) begin
        check("valid_timeout", 0, 1);
        timed_out = 1'b1;
      end else begin
        if (!bp) check("valid_latency", waited, k + 1);
        check("out_row", out_row, e / n);
        check("out_col", out_col, e % n);
        check("out_data", out_data, expect_c(e / n, e % n, k));
        check("no_early_done", done, 0);
        if (bp) begin
          for (int s = 0; s < 7; s++) begin
            wr_en   = 1'b1;
            wr_sel  = 1'($urandom_range(1));
            wr_row  = IW'($urandom_range(MD - 1));
            wr_col  = IW'($urandom_range(MD - 1));
            wr_data = DW'($urandom);
            tick();
          end
          wr_en = 1'b0;
          check("bp_valid_held", out_valid, 1);
          check("bp_row_held", out_row, e / n);
          check("bp_col_held", out_col, e % n);
          check("bp_data_held", out_data, expect_c(e / n, e % n, k));
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end else begin
          tick();
        end
      end
    end
    if (!timed_out) begin
      check("done_pulse", done, 1);
      tick();
      check("done_cleared", done, 0);
      check("busy_cleared", busy, 0);
      check("valid_cleared", out_valid, 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, k, n;
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    dim_m = '0; dim_k = '0; dim_n = '0; start = 1'b0; out_ready = 1'b0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        ma[r][c] = 0;
        mb[r][c] = 0;
      end
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);

    // Identity A times counting B reproduces B.
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        write_op(1'b0, r, c, (r == c) ? 1 : 0);
        write_op(1'b1, r, c, r * 4 + c);
      end
    run(4, 4, 4, 1'b0);

    // Signed extremes.
    write_op(1'b0, 0, 0, -128);
    write_op(1'b1, 0, 0, -128);
    run(1, 1, 1, 1'b0);
    check("ext_neg_neg", expect_c(0, 0, 1), 16384);
    write_op(1'b1, 0, 0, 127);
    run(1, 1, 1, 1'b0);
    check("ext_neg_pos", expect_c(0, 0, 1), -16256);

    // Non-square 2x3 * 3x1.
    for (int c = 0; c < 3; c++) begin
      write_op(1'b0, 0, c, c + 1);
      write_op(1'b0, 1, c, c + 4);
      write_op(1'b1, c, 0, 1);
    end
    run(2, 3, 1, 1'b0);
    check("nonsq_r0", expect_c(0, 0, 3), 6);
    check("nonsq_r1", expect_c(1, 0, 3), 15);

    // Backpressure with writes attempted while busy, then a rerun on the same model.
    load_random();
    run(3, 4, 2, 1'b1);
    run(3, 4, 2, 1'b0);

    // Write and start in the same cycle: the new operand is used.
    write_op(1'b1, 0, 0, 3);
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = DW'(5);
    ma[0][0] = 5;
    run(1, 1, 1, 1'b0);

    // Illegal configurations.
    dim_m = 3'd2; dim_k = 3'd0; dim_n = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_k0", cfg_err, 1);
    check("cfg_busy_k0", busy, 0);
    tick();
    check("cfg_err_pulse", cfg_err, 0);
    for (int s = 0; s < 4; s++) begin
      check("cfg_no_valid", out_valid, 0);
      tick();
    end
    dim_m = 3'd5; dim_k = 3'd2; dim_n = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_m5", cfg_err, 1);
    check("cfg_busy_m5", busy, 0);
    tick();

    // Reset in the middle of MAC clears outputs and both matrices.
    load_random();
    dim_m = 3'd4; dim_k = 3'd4; dim_n = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_done", done, 0);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        ma[r][c] = 0;
        mb[r][c] = 0;
      end
    run(4, 4, 4, 1'b0);

    // Accumulator overflow: 4 x (-128 * -128) = 65536 exceeds 16 bits.
    for (int kk = 0; kk < 4; kk++) begin
      write_op(1'b0, 0, kk, -128);
      write_op(1'b1, kk, 0, -128);
    end
    run(1, 4, 1, 1'b0);
`ifdef MM_SAT_EN
    check("ovf_model", expect_c(0, 0, 4), 32767);
`else
    check("ovf_model", expect_c(0, 0, 4), 0);
`endif

    // Randomized operands and dimensions.
    for (int t = 0; t < 6; t++) begin
      load_random();
      m = int'($urandom_range(MD - 1)) + 1;
      k = int'($urandom_range(MD - 1)) + 1;
      n = int'($urandom_range(MD - 1)) + 1;
      run(m, k, n, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
